// File: rtl/mont_pkg.sv
// Shared types and sizing helpers for the bit-serial Montgomery multiplier.
// Build option MONT_FINAL_SUB_EN adds the final conditional subtraction (affects mont_latency).
package mont_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECOMP,
    LOOP,
    SUB,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 1024;
  // Two guard bits keep C + addend (< 4M) from overflowing.
  localparam int C_EXTRA_BITS  = 2;

  function automatic int c_width(input int width);
    return width + C_EXTRA_BITS;
  endfunction

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int mont_latency(input int width);
`ifdef MONT_FINAL_SUB_EN
    return width + 3;
`else
    return width + 2;
`endif
  endfunction

endpackage

// File: rtl/mont_wide_adder.sv
// Wide add/subtract unit shared by every datapath step of the Montgomery multiplier.
// Kept separate so a faster adder structure can be dropped in without touching the control.
module mont_wide_adder
  import mont_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH + C_EXTRA_BITS
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Subtraction as a + ~b + 1 so there is only one carry chain.
  assign sum = op_a + (op_b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/mont_mult_param.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Macro MONT_FINAL_SUB_EN enables the final C >= M subtraction (fully reduced result).
module mont_mult_param
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int C_W   = c_width(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, m_reg;
  logic [WIDTH:0]   bm_reg;
  logic [C_W-1:0]   c_reg;
  logic [CNT_W-1:0] cnt;

  logic             a_bit, q_bit;
  logic [C_W-1:0]   addend;
  logic [C_W-1:0]   add_a, add_b, add_sum;
  logic             add_sub;

  assign a_bit = a_reg[0];
  assign q_bit = c_reg[0] ^ (a_bit & b_reg[0]);

  always_comb begin
    addend = '0;
    case ({a_bit, q_bit})
      2'b00:   addend = '0;
      2'b01:   addend = {2'b00, m_reg};
      2'b10:   addend = {2'b00, b_reg};
      default: addend = {1'b0, bm_reg};
    endcase
  end

  always_comb begin
    add_a   = c_reg;
    add_b   = addend;
    add_sub = 1'b0;
    case (state)
      PRECOMP: begin
        add_a = {2'b00, b_reg};
        add_b = {2'b00, m_reg};
      end
`ifdef MONT_FINAL_SUB_EN
      SUB: begin
        add_b   = {2'b00, m_reg};
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  mont_wide_adder #(
    .W(C_W)
  ) u_adder (
    .op_a(add_a),
    .op_b(add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PRECOMP;
      PRECOMP: state_next = LOOP;
      LOOP: begin
        if (cnt == LAST_ITER) begin
`ifdef MONT_FINAL_SUB_EN
          state_next = SUB;
`else
          state_next = DONE;
`endif
        end
      end
      SUB:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured once per accepted start; A is consumed LSB first.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_reg <= in_a;
      b_reg <= in_b;
      m_reg <= in_m;
    end else if (state == LOOP) begin
      a_reg <= a_reg >> 1;
    end
    if (state == PRECOMP) bm_reg <= add_sum[WIDTH:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_reg  <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= (state == DONE);
      // Busy spans the done cycle too, which is also the first cycle a new start can land.
      busy <= (state_next != IDLE) || (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            c_reg <= '0;
            cnt   <= '0;
          end
        end
        LOOP: begin
          c_reg <= {1'b0, add_sum[C_W-1:1]};
          cnt   <= cnt + CNT_W'(1);
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          // C < 2M, so a negative difference always shows up in the top bit.
          if (!add_sum[C_W-1]) c_reg <= add_sum;
        end
`endif
        DONE:    result <= c_reg[WIDTH-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mult_param.sv
// Scoreboard bench for mont_mult_param at WIDTH=8 with hand-computed Montgomery products.
// Honours MONT_FINAL_SUB_EN when it is defined for the whole compile.
module tb_mont_mult_param;

  localparam int W = 8;
`ifdef MONT_FINAL_SUB_EN
  localparam int EXP_LAT = 11;
`else
  localparam int EXP_LAT = 10;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] in_a, in_b, in_m, result;
  logic         done, busy;

  mont_mult_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_m  (in_m),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int exp;
    int m;
    int t0;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int m;
    int r;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   vec_count   = 0;
  int   miscompares = 0;

  task automatic check_output(input string name, input int actual, input int required);
    vec_count++;
    if (actual != required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
`ifdef MONT_FINAL_SUB_EN
        check_output("result", int'(result), e.exp);
`else
        check_output("result_mod", int'(result) % e.m, e.exp);
        check_output("result_lt_2m", int'(int'(result) < 2 * e.m), 1);
`endif
        check_output("latency", cycle - e.t0, EXP_LAT);
        check_output("busy_at_done", int'(busy), 1);
      end
    end
  end

  task automatic apply_stimulus(input int a, input int b, input int m, input int r,
                                input bit expect_done);
    in_a  = W'(a);
    in_b  = W'(b);
    in_m  = W'(m);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (expect_done) sb.push_back('{r, m, cycle});
    start = 1'b0;
    in_a  = W'($urandom);
    in_b  = W'($urandom);
    in_m  = W'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check_output("done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    in_m  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vecs.push_back('{9, 5, 13, 5});
    vecs.push_back('{1, 1, 13, 3});
    vecs.push_back('{0, 7, 13, 0});
    vecs.push_back('{12, 12, 13, 3});
    vecs.push_back('{100, 50, 127, 87});
    vecs.push_back('{0, 0, 1, 0});
    vecs.push_back('{2, 2, 3, 1});
`ifdef MONT_FINAL_SUB_EN
    vecs.push_back('{250, 250, 251, 201});
    vecs.push_back('{2, 3, 251, 202});
    vecs.push_back('{200, 100, 255, 110});
`endif

    // Each new start is issued in the done cycle, exercising back-to-back acceptance.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, 1'b1);
      wait_done();
    end

    apply_stimulus(9, 5, 13, 5, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);
    check_output("busy_idle", int'(busy), 0);

    apply_stimulus(100, 50, 127, 87, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    check_output("abort_result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(100, 50, 127, 87, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    check_output("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
